// File: rtl/line_clear.sv
// ---------------------------------------------------------------------------
// line_clear
//
// Removes completed rows from a ROWS x COLS playfield of CW-bit colour cells.
// A start request in IDLE snapshots board_i into an internal buffer. The
// buffer is then scanned bottom-up, one row per cycle. When a row is full, a
// one-cycle shift drops every row above it down by one and clears row 0. The
// same row index is then re-scanned, because a full row may have dropped into
// it. When the scan walks off the top, the result is published and a
// one-cycle done pulse is raised.
//
// Row 0 is the top (spawn) row and row ROWS-1 is the bottom row. A cell value
// of zero means empty, and any nonzero value means occupied.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   start          in   request a clear pass; only honoured in IDLE
//   board_i        in   board to process; captured on the accepted start cycle
//   busy           out  high from the cycle after acceptance through the done cycle
//   done           out  one-cycle pulse; board_o / lines_cleared valid from here
//   board_o        out  processed board; held until the next done
//   score          out  cumulative score (only with LINE_CLEAR_SCORE_EN)
//   lines_cleared  out  rows removed by the last pass
//
// Configuration
//   LINE_CLEAR_SCORE_EN  when defined, adds the score port and a saturating
//                        score accumulator, updated when a pass completes.
// ---------------------------------------------------------------------------
module line_clear #(
    parameter int unsigned ROWS = 22,
    parameter int unsigned COLS = 10,
    parameter int unsigned CW   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ROWS-1:0][COLS-1:0][CW-1:0] board_i,
    output logic                             busy,
    output logic                             done,
    output logic [ROWS-1:0][COLS-1:0][CW-1:0] board_o,
`ifdef LINE_CLEAR_SCORE_EN
    output logic [15:0]                      score,
`endif
    output logic [4:0]                       lines_cleared
);

    typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] board_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StShift,
        StDone
    } state_e;

    state_e     state_q, state_d;

    board_t     buf_q, buf_d;
    logic [4:0] r_q, r_d;
    logic [4:0] count_q, count_d;
    board_t     board_o_q, board_o_d;
    logic [4:0] lines_q, lines_d;

    logic       row_full;
    logic       scan_end;

    // ------------------------------------------------------------------
    // Row evaluation: the row under the pointer is full when every cell
    // holds a nonzero colour.
    // ------------------------------------------------------------------
    always_comb begin
        row_full = 1'b1;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (buf_q[r_q][c] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    // The scan finishes on a non-full top row.
    assign scan_end = (state_q == StScan) && !row_full && (r_q == 5'd0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (row_full) begin
                    state_d = StShift;
                end else if (r_q == 5'd0) begin
                    state_d = StDone;
                end
            end
            StShift: begin
                state_d = StScan;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        buf_d     = buf_q;
        r_d       = r_q;
        count_d   = count_q;
        board_o_d = board_o_q;
        lines_d   = lines_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    buf_d   = board_i;
                    r_d     = 5'(ROWS - 1);
                    count_d = 5'd0;
                end
            end
            StScan: begin
                if (!row_full && (r_q != 5'd0)) begin
                    r_d = r_q - 5'd1;
                end
                // The result is latched on entry to DONE so that it is
                // already valid while done is high. The buffer cannot change
                // in DONE, so this matches the buffer contents in that cycle.
                if (scan_end) begin
                    board_o_d = buf_q;
                    lines_d   = count_q;
                end
            end
            StShift: begin
                // Rows 1..r take the contents of the row above. Rows below
                // r are untouched.
                for (int unsigned i = 1; i < ROWS; i++) begin
                    if (i <= {27'd0, r_q}) begin
                        buf_d[i] = buf_q[i-1];
                    end
                end
                buf_d[0] = '0;
                count_d  = count_q + 5'd1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            r_q       <= '0;
            count_q   <= '0;
            board_o_q <= '0;
            lines_q   <= '0;
        end else begin
            buf_q     <= buf_d;
            r_q       <= r_d;
            count_q   <= count_d;
            board_o_q <= board_o_d;
            lines_q   <= lines_d;
        end
    end

    assign board_o       = board_o_q;
    assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
    // ------------------------------------------------------------------
    // Saturating score accumulator. It is updated together with the
    // published result, so the new score is visible in the done cycle.
    // ------------------------------------------------------------------
    logic [15:0] score_q, score_d;
    logic [15:0] score_add;
    logic [16:0] score_sum;

    always_comb begin
        case (count_q)
            5'd0:    score_add = 16'd0;
            5'd1:    score_add = 16'd100;
            5'd2:    score_add = 16'd300;
            5'd3:    score_add = 16'd500;
            default: score_add = 16'd800;
        endcase
    end

    always_comb begin
        score_sum = {1'b0, score_q} + {1'b0, score_add};
        score_d   = score_q;
        if (scan_end) begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`endif

endmodule

// File: tb/tb_line_clear.sv
module tb_line_clear;

    typedef logic [21:0][9:0][2:0] board_t;

    logic       clk;
    logic       rst;
    logic       start;
    board_t     board_i;
    logic       busy;
    logic       done;
    board_t     board_o;
    logic [4:0] lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score;
`endif

    int checks;
    int failures;

    line_clear dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .board_i       (board_i),
        .busy          (busy),
        .done          (done),
        .board_o       (board_o),
`ifdef LINE_CLEAR_SCORE_EN
        .score         (score),
`endif
        .lines_cleared (lines_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- directed boards and their expected results ---------
    function automatic board_t fill_row(input board_t b, input int r, input logic [2:0] v);
        board_t t = b;
        for (int c = 0; c < 10; c++) t[r][c] = v;
        return t;
    endfunction

    function automatic board_t board_case2();
        board_t b = '0;
        b = fill_row(b, 21, 3'b011);
        b[20][4] = 3'b110;
        return b;
    endfunction

    function automatic board_t exp_case2();
        board_t b = '0;
        b[21][4] = 3'b110;
        return b;
    endfunction

    function automatic board_t board_case3();
        board_t b = '0;
        for (int r = 18; r <= 21; r++) b = fill_row(b, r, 3'b101);
        b[17][0] = 3'b001;
        return b;
    endfunction

    function automatic board_t exp_case3();
        board_t b = '0;
        b[21][0] = 3'b001;
        return b;
    endfunction

    // Drives one pass. Cycle n is the clock period that ends at edge n after
    // the start-sample edge, and it is observed at that period's falling edge.
    // The board input is scrambled after acceptance. lat stays -1 on timeout.
    task automatic run_pass(input board_t b, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        board_i = b;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        board_i = ~b;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    // ---------------- tests ---------------------------------------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; board_i = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (board_o !== '0) begin failures++; $display("FAIL reset_board: got %h want 0", board_o); end
        checks++;
        if (lines_cleared !== 5'd0) begin
            failures++; $display("FAIL reset_lines: got %0d want 0", lines_cleared);
        end
`ifdef LINE_CLEAR_SCORE_EN
        checks++;
        if (score !== 16'd0) begin failures++; $display("FAIL reset_score: got %0d want 0", score); end
`endif
    endtask

    task automatic test_empty();
        int lat; bit bok;
        run_pass('0, lat, bok);
        checks++;
        if (lat !== 23) begin failures++; $display("FAIL empty_latency: got %0d want 23", lat); end
        checks++;
        if (bok !== 1'b1) begin failures++; $display("FAIL empty_busy: got %b want 1", bok); end
        checks++;
        if (lines_cleared !== 5'd0) begin
            failures++; $display("FAIL empty_lines: got %0d want 0", lines_cleared);
        end
        checks++;
        if (board_o !== '0) begin failures++; $display("FAIL empty_board: got %h want 0", board_o); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL empty_after: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_single();
        int lat; bit bok;
        run_pass(board_case2(), lat, bok);
        checks++;
        if (lat !== 25) begin failures++; $display("FAIL single_latency: got %0d want 25", lat); end
        checks++;
        if (lines_cleared !== 5'd1) begin
            failures++; $display("FAIL single_lines: got %0d want 1", lines_cleared);
        end
        checks++;
        if (board_o !== exp_case2()) begin
            failures++; $display("FAIL single_board: got %h want %h", board_o, exp_case2());
        end
    endtask

    task automatic test_four();
        int lat; bit bok;
        run_pass(board_case3(), lat, bok);
        checks++;
        if (lat !== 31) begin failures++; $display("FAIL four_latency: got %0d want 31", lat); end
        checks++;
        if (lines_cleared !== 5'd4) begin
            failures++; $display("FAIL four_lines: got %0d want 4", lines_cleared);
        end
        checks++;
        if (board_o !== exp_case3()) begin
            failures++; $display("FAIL four_board: got %h want %h", board_o, exp_case3());
        end
    endtask

    task automatic test_split();
        int lat; bit bok;
        board_t b = '0;
        board_t e = '0;
        b = fill_row(b, 21, 3'b111);
        b = fill_row(b, 19, 3'b100);
        b[20][9] = 3'b010;
        e[21][9] = 3'b010;
        run_pass(b, lat, bok);
        checks++;
        if (lat !== 27) begin failures++; $display("FAIL split_latency: got %0d want 27", lat); end
        checks++;
        if (lines_cleared !== 5'd2) begin
            failures++; $display("FAIL split_lines: got %0d want 2", lines_cleared);
        end
        checks++;
        if (board_o !== e) begin failures++; $display("FAIL split_board: got %h want %h", board_o, e); end
    endtask

    task automatic test_top_row();
        int lat; bit bok;
        board_t b = '0;
        b = fill_row(b, 0, 3'b001);
        run_pass(b, lat, bok);
        checks++;
        if (lat !== 25) begin failures++; $display("FAIL top_latency: got %0d want 25", lat); end
        checks++;
        if (lines_cleared !== 5'd1 || board_o !== '0) begin
            failures++;
            $display("FAIL top_result: got lines=%0d board=%h want 1 and 0", lines_cleared, board_o);
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        int lat = -1;
        board_t first_o = '0;
        @(negedge clk);
        board_i = board_case2();
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 5) begin start = 1'b1; board_i = board_case3(); end
            if (c == 6) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin lat = c; first_o = board_o; end
            end
        end
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL ignore_pulses: got %0d want 1", ndone); end
        checks++;
        if (lat !== 25) begin failures++; $display("FAIL ignore_latency: got %0d want 25", lat); end
        checks++;
        if (first_o !== exp_case2()) begin
            failures++; $display("FAIL ignore_board: got %h want %h", first_o, exp_case2());
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        @(negedge clk);
        board_i = board_case3();
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++;
        if (board_o !== '0 || lines_cleared !== 5'd0) begin
            failures++;
            $display("FAIL midrst_result: got lines=%0d board=%h want 0", lines_cleared, board_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin failures++; $display("FAIL midrst_done: got %0d want 0", ndone); end
    endtask

`ifdef LINE_CLEAR_SCORE_EN
    task automatic test_score();
        int lat; bit bok;
        checks++;
        if (score !== 16'd0) begin failures++; $display("FAIL score_reset: got %0d want 0", score); end
        run_pass(board_case3(), lat, bok);
        checks++;
        if (score !== 16'd800) begin failures++; $display("FAIL score_four: got %0d want 800", score); end
        run_pass(board_case2(), lat, bok);
        checks++;
        if (score !== 16'd900) begin failures++; $display("FAIL score_total: got %0d want 900", score); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        board_i  = '0;
        test_reset();
        test_empty();
        test_single();
        test_four();
        test_split();
        test_top_row();
        test_start_ignored();
        test_reset_mid();
`ifdef LINE_CLEAR_SCORE_EN
        test_score();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
